// File: rtl/warface_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : warface_pkg
//  Description : Shared types and register map for the CHR split scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package warface_pkg;

    localparam int NUM_SPLITS = 4;

    localparam logic [2:0] c_reg_base = 3'd0;
    localparam logic [2:0] c_reg_ctrl = 3'd1;
    localparam logic [2:0] c_reg_sel  = 3'd2;
    localparam logic [2:0] c_reg_line = 3'd3;
    localparam logic [2:0] c_reg_bank = 3'd4;
    localparam logic [2:0] c_reg_ack  = 3'd5;

    typedef struct packed {
        logic [7:0] line;
        logic [4:0] bank;
        logic       irq_en;
    } split_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

    function automatic logic [2:0] clamp_count(input logic [2:0] cnt);
        return (cnt > 3'd4) ? 3'd4 : cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chr_split_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : chr_split_scheduler_if
//  Description : CPU register port, frame timing strobes and scheduler outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface chr_split_scheduler_if #(
    parameter int BANK_W = 5
);
    logic              reg_wr;
    logic [2:0]        reg_addr;
    logic [7:0]        reg_data;
    logic              frame_start;
    logic              scanline_tick;
    logic [BANK_W-1:0] chr_bank;
    logic              irq_n;
    logic [2:0]        split_index;
    logic              active;

    modport master (
        output reg_wr, reg_addr, reg_data, frame_start, scanline_tick,
        input  chr_bank, irq_n, split_index, active
    );

    modport slave (
        input  reg_wr, reg_addr, reg_data, frame_start, scanline_tick,
        output chr_bank, irq_n, split_index, active
    );
endinterface
`default_nettype wire

// File: rtl/split_table.sv
`default_nettype none
// ============================================================================
//  Module      : split_table
//  Description : Shadow/active split table with CPU write port and frame copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module split_table
    import warface_pkg::*;
#(
    parameter int NUM_SPLITS = 4
) (
    input  wire logic         m2,
    input  wire logic         rst_n,
    input  wire logic         wr_en,
    input  wire logic [2:0]   wr_addr,
    input  wire logic [7:0]   wr_data,
    input  wire logic         frame_start,
    input  wire logic [1:0]   rd_idx,
    output split_entry_t      rd_entry,
    output logic [4:0]        shadow_base,
    output logic [2:0]        shadow_count,
    output logic              shadow_enable,
    output logic [2:0]        act_count
);

    split_entry_t r_shadow [NUM_SPLITS];
    split_entry_t r_active [NUM_SPLITS];
    logic [1:0]   r_sel;
    logic [4:0]   r_base;
    logic [2:0]   r_count;
    logic         r_enable;
    logic [2:0]   r_act_count;

    // Base bank and enable take effect through the scheduler at frame_start,
    // so only the entries and count need a separate active copy.
    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= 2'd0;
            r_base      <= 5'd0;
            r_count     <= 3'd0;
            r_enable    <= 1'b0;
            r_act_count <= 3'd0;
            for (int i = 0; i < NUM_SPLITS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    c_reg_base: r_base <= wr_data[4:0];
                    c_reg_ctrl: begin
                        r_count  <= clamp_count(wr_data[2:0]);
                        r_enable <= wr_data[7];
                    end
                    c_reg_sel:  r_sel <= wr_data[1:0];
                    c_reg_line: r_shadow[r_sel].line <= wr_data;
                    c_reg_bank: begin
                        r_shadow[r_sel].bank   <= wr_data[4:0];
                        r_shadow[r_sel].irq_en <= wr_data[7];
                    end
                    default: ;
                endcase
            end
            if (frame_start) begin
                r_act_count <= r_count;
                for (int i = 0; i < NUM_SPLITS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    assign rd_entry      = r_active[rd_idx];
    assign shadow_base   = r_base;
    assign shadow_count  = r_count;
    assign shadow_enable = r_enable;
    assign act_count     = r_act_count;

endmodule
`default_nettype wire

// File: rtl/chr_split_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : chr_split_scheduler
//  Description : Per-frame programmable CHR $0000 bank split scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module chr_split_scheduler #(
    parameter int NUM_SPLITS = 4,
    parameter int BANK_W     = 5
) (
    input  wire logic            m2,
    input  wire logic            rst_n,
    chr_split_scheduler_if.slave bus
);
    import warface_pkg::*;

    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_armed = ARMED;
    localparam logic [1:0] c_st_done  = DONE;

    logic [1:0]        r_state;
    logic [2:0]        r_idx;
    logic [7:0]        r_line;
    logic [BANK_W-1:0] r_bank;
    logic              r_irq_n;

    split_entry_t      w_entry;
    logic [4:0]        w_shadow_base;
    logic [2:0]        w_shadow_count;
    logic              w_shadow_enable;
    logic [2:0]        w_act_count;
    logic              w_fire;
    logic              w_irq_set;
    logic              w_irq_ack;

    split_table #(
        .NUM_SPLITS (NUM_SPLITS)
    ) u_split_table (
        .m2            (m2),
        .rst_n         (rst_n),
        .wr_en         (bus.reg_wr),
        .wr_addr       (bus.reg_addr),
        .wr_data       (bus.reg_data),
        .frame_start   (bus.frame_start),
        .rd_idx        (r_idx[1:0]),
        .rd_entry      (w_entry),
        .shadow_base   (w_shadow_base),
        .shadow_count  (w_shadow_count),
        .shadow_enable (w_shadow_enable),
        .act_count     (w_act_count)
    );

    // A frame_start in the same cycle aborts any pending split.
    assign w_fire    = (r_state == c_st_armed) && !bus.frame_start && (r_line >= w_entry.line);
    assign w_irq_set = w_fire && w_entry.irq_en;
    assign w_irq_ack = bus.reg_wr && (bus.reg_addr == c_reg_ack);

    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_line <= 8'd0;
        end else if (bus.frame_start) begin
            r_line <= 8'd0;
        end else if (bus.scanline_tick && (r_line != 8'hFF)) begin
            r_line <= r_line + 8'd1;
        end
    end

    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_n <= 1'b1;
        end else if (w_irq_set) begin
            r_irq_n <= 1'b0;
        end else if (w_irq_ack) begin
            r_irq_n <= 1'b1;
        end
    end

    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_idx   <= 3'd0;
            r_bank  <= '0;
        end else if (bus.frame_start) begin
            r_idx <= 3'd0;
            if (w_shadow_enable) begin
                r_bank  <= BANK_W'(w_shadow_base);
                r_state <= (w_shadow_count == 3'd0) ? c_st_done : c_st_armed;
            end else begin
                r_state <= c_st_idle;
            end
        end else if (w_fire) begin
            r_bank <= BANK_W'(w_entry.bank);
            r_idx  <= r_idx + 3'd1;
            if ((r_idx + 3'd1) == w_act_count) begin
                r_state <= c_st_done;
            end
        end
    end

    // While idle the output bank tracks the CPU-written base directly.
    assign bus.chr_bank    = (r_state == c_st_idle) ? BANK_W'(w_shadow_base) : r_bank;
    assign bus.irq_n       = r_irq_n;
    assign bus.split_index = r_idx;
    assign bus.active      = (r_state != c_st_idle);

endmodule
`default_nettype wire
